alu_sequencer: RTL and testbench

- Fetch/decode/execute sequencer that sits directly upstream of the 8-bit ALU.
- Fetches instruction bytes, and immediates where needed, over a req/ack program-memory port.
- Holds the 4x8 register file and presents operands, the instruction word and a one-cycle strobe to the ALU.
- Writes the ALU result and flags back into its own state.

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer for an external 8-bit ALU: fetches opcode and
// immediate bytes over a req/ack port, owns the 4x8 register file and flag register.
module alu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [7:0]       imem_addr,
    input  logic [7:0]       imem_rdata,
    input  logic             imem_ack,
    output logic [7:0]       alu_word,
    output logic [7:0]       alu_in1,
    output logic [7:0]       alu_in2,
    output logic             alu_strobe,
    input  logic [7:0]       alu_out,
    input  logic [1:0]       alu_flags,
    output logic [1:0]       flags,
    output logic [7:0]       pc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    input  logic [1:0]       dbg_sel,
    output logic [7:0]       dbg_data
);

    typedef enum logic [1:0] {FETCH, FETCH_IMM, EXEC, HALT} state_t;

    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_MOV = 4'b0010;
    localparam logic [3:0] OP_HLT = 4'b0011;

    state_t           state_reg, state_next;
    logic             req_reg, req_next;
    logic [7:0]       pc_reg, pc_next;
    logic [7:0]       word_reg, word_next;
    logic [7:0]       in1_reg, in1_next;
    logic [7:0]       in2_reg, in2_next;
    logic             strobe_reg, strobe_next;
    logic [1:0]       flags_reg, flags_next;
    logic             halted_reg, halted_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       rf_reg [4];

    logic             we;
    logic [1:0]       wa;
    logic [7:0]       wd;
    logic [3:0]       wr_en;
    logic             retire;
    logic [3:0]       fop;

    function automatic logic needs_imm(input logic [3:0] op);
        return op inside {4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1001, 4'b1011, OP_MVI};
    endfunction

    function automatic logic is_reg_alu(input logic [3:0] op);
        return op inside {4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010};
    endfunction

    function automatic logic is_compare(input logic [3:0] op);
        return op inside {4'b0111, 4'b1111};
    endfunction

    assign fop = imem_rdata[7:4];

    // word_reg doubles as the instruction register while EXEC is pending.
    always_comb begin
        state_next  = state_reg;
        req_next    = req_reg;
        pc_next     = pc_reg;
        word_next   = word_reg;
        in1_next    = in1_reg;
        in2_next    = in2_reg;
        strobe_next = 1'b0;
        flags_next  = flags_reg;
        halted_next = halted_reg;
        we          = 1'b0;
        wa          = word_reg[3:2];
        wd          = alu_out;
        retire      = 1'b0;

        case (state_reg)
            FETCH: begin
                if (!req_reg) begin
                    req_next = 1'b1;
                end else if (imem_ack) begin
                    req_next  = 1'b0;
                    pc_next   = pc_reg + 8'd1;
                    word_next = imem_rdata;
                    if (needs_imm(fop)) begin
                        state_next = FETCH_IMM;
                    end else if (is_reg_alu(fop)) begin
                        state_next  = EXEC;
                        strobe_next = 1'b1;
                        in1_next    = rf_reg[imem_rdata[1:0]];
                        in2_next    = rf_reg[imem_rdata[3:2]];
                    end else if (fop == OP_HLT) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                        retire      = 1'b1;
                    end else begin
                        retire = 1'b1;
                        if (fop == OP_MOV) begin
                            we = 1'b1;
                            wa = imem_rdata[3:2];
                            wd = rf_reg[imem_rdata[1:0]];
                        end
                    end
                end
            end
            FETCH_IMM: begin
                if (!req_reg) begin
                    req_next = 1'b1;
                end else if (imem_ack) begin
                    req_next = 1'b0;
                    pc_next  = pc_reg + 8'd1;
                    if (word_reg[7:4] == OP_MVI) begin
                        we         = 1'b1;
                        wd         = imem_rdata;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next  = EXEC;
                        strobe_next = 1'b1;
                        in1_next    = imem_rdata;
                        in2_next    = rf_reg[word_reg[3:2]];
                    end
                end
            end
            EXEC: begin
                flags_next = alu_flags;
                we         = !is_compare(word_reg[7:4]);
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
            end
            default: state_next = FETCH;
        endcase

        cnt_next = cnt_reg;
        if (retire && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= FETCH;
            req_reg    <= 1'b0;
            pc_reg     <= RESET_PC;
            word_reg   <= '0;
            in1_reg    <= '0;
            in2_reg    <= '0;
            strobe_reg <= 1'b0;
            flags_reg  <= '0;
            halted_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            req_reg    <= req_next;
            pc_reg     <= pc_next;
            word_reg   <= word_next;
            in1_reg    <= in1_next;
            in2_reg    <= in2_next;
            strobe_reg <= strobe_next;
            flags_reg  <= flags_next;
            halted_reg <= halted_next;
            cnt_reg    <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_en
            assign wr_en[gi] = we && (wa == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (wr_en[i]) rf_reg[i] <= wd;
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign alu_word    = word_reg;
    assign alu_in1     = in1_reg;
    assign alu_in2     = in2_reg;
    assign alu_strobe  = strobe_reg;
    assign flags       = flags_reg;
    assign pc          = pc_reg;
    assign halted      = halted_reg;
    assign instr_count = cnt_reg;
    assign dbg_data    = rf_reg[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory responder, behavioural ALU and an
// instruction-level reference model checked at every retirement.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_rdata = 8'h00;
    logic        imem_ack = 1'b0;
    logic [7:0]  alu_word, alu_in1, alu_in2;
    logic        alu_strobe;
    logic [7:0]  alu_out;
    logic [1:0]  alu_flags;
    logic [1:0]  flags;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] instr_count;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;

    logic [7:0] mem [256];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  resp_en = 0, spur_en = 0, mon_en = 0, pending = 0;
    int  fixed_lat = 0;
    int  wait_cnt = 0;
    logic [7:0] req_addr;

    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    logic [1:0] m_flags;
    int         m_cnt;
    bit         m_halted;
    logic [1:0] flag_hist [$];
    int         strobe_cycles;
    logic [7:0] last_in1, last_in2;
    logic [15:0] last_cnt = 16'd0;
    bit         strobe_prev = 0;

    alu_sequencer #(.RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .alu_word(alu_word), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_strobe(alu_strobe), .alu_out(alu_out), .alu_flags(alu_flags),
        .flags(flags), .pc(pc), .halted(halted), .instr_count(instr_count),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ALU behaviour: result is in2 op in1; flags {carry/borrow/less, zero}.
    function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a1,
                                           input logic [7:0] a2);
        logic [8:0] s;
        logic [7:0] r;
        logic c, z;
        s = 9'd0; r = 8'd0; c = 1'b0;
        case (op)
            4'h4, 4'hC: begin s = {1'b0, a2} + {1'b0, a1}; r = s[7:0]; c = s[8]; end
            4'h5, 4'hD: begin r = a2 - a1; c = (a2 < a1); end
            4'h6, 4'hE: r = a2 & a1;
            4'h8, 4'h9: r = a2 | a1;
            4'hA, 4'hB: r = a2 ^ a1;
            4'h7, 4'hF: begin r = a2 - a1; c = (a1 < a2); end
            default: r = 8'd0;
        endcase
        z = (op == 4'h7 || op == 4'hF) ? (a1 == a2) : (r == 8'd0);
        return {c, z, r};
    endfunction

    assign {alu_flags, alu_out} = alu_ref(alu_word[7:4], alu_in1, alu_in2);

    function automatic bit has_imm(input logic [3:0] op);
        return op inside {4'h1, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_r[k] = 8'h00;
        m_pc = 8'h00; m_flags = 2'b00; m_cnt = 0; m_halted = 0;
    endtask

    task automatic expected_ops(output logic [7:0] ew, output logic [7:0] e1,
                                output logic [7:0] e2);
        logic [7:0] nxt;
        ew  = mem[m_pc];
        nxt = m_pc + 8'd1;
        e1  = has_imm(ew[7:4]) ? mem[nxt] : m_r[ew[1:0]];
        e2  = m_r[ew[3:2]];
    endtask

    task automatic model_step();
        logic [7:0] ir, imm, src;
        logic [9:0] fr;
        ir = mem[m_pc]; m_pc = m_pc + 8'd1; imm = 8'h00;
        if (has_imm(ir[7:4])) begin imm = mem[m_pc]; m_pc = m_pc + 8'd1; end
        case (ir[7:4])
            4'h0: ;
            4'h1: m_r[ir[3:2]] = imm;
            4'h2: m_r[ir[3:2]] = m_r[ir[1:0]];
            4'h3: m_halted = 1;
            default: begin
                src = has_imm(ir[7:4]) ? imm : m_r[ir[1:0]];
                fr  = alu_ref(ir[7:4], src, m_r[ir[3:2]]);
                m_flags = fr[9:8];
                if (ir[7:4] != 4'h7 && ir[7:4] != 4'hF) m_r[ir[3:2]] = fr[7:0];
            end
        endcase
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Program memory: per-byte latency, address stability, optional stray acks.
    initial begin
        forever begin
            @(negedge clk);
            if (!resp_en) continue;
            if (imem_ack) begin
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (!pending) begin
                    pending  = 1;
                    req_addr = imem_addr;
                    wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end else begin
                    check("addr_stable", imem_addr, req_addr);
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    pending    = 0;
                end else begin
                    wait_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = 8'($urandom);
            end
        end
    end

    // Retirement monitor: operands at strobe, architectural state at retire.
    initial begin : monitor
        logic [7:0] ew, e1, e2;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                strobe_prev = 0;
                last_cnt    = instr_count;
                continue;
            end
            if (alu_strobe) begin
                check("strobe_width", 32'(strobe_prev), 0);
                expected_ops(ew, e1, e2);
                check("alu_word", alu_word, ew);
                check("alu_in1", alu_in1, e1);
                check("alu_in2", alu_in2, e2);
                last_in1 = alu_in1;
                last_in2 = alu_in2;
                strobe_cycles++;
            end
            strobe_prev = alu_strobe;
            if (instr_count !== last_cnt) begin
                model_step();
                last_cnt = instr_count;
                flag_hist.push_back(flags);
                check("count", instr_count, 32'(m_cnt));
                check("pc", pc, m_pc);
                check("flags", flags, m_flags);
                check("halted", halted, 32'(m_halted));
                for (int k = 0; k < 4; k++) begin
                    dbg_sel = 2'(k);
                    #1;
                    check("regfile", dbg_data, m_r[k]);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; pending = 0;
        model_reset();
        flag_hist.delete();
        strobe_cycles = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int cyc = 0;
        while (halted !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", 32'(halted), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    task automatic clear_mem(input logic [7:0] fill);
        for (int a = 0; a < 256; a++) mem[a] = fill;
    endtask

    initial begin : main
        logic [7:0] v;
        int cyc;
        int a;
        logic [3:0] op;

        clear_mem(8'h00);
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 0);
        check("rst_strobe", 32'(alu_strobe), 0);
        check("rst_word", alu_word, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_flags", flags, 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_count", instr_count, 0);
        for (int k = 0; k < 4; k++) begin
            read_reg(2'(k), v);
            check("rst_reg", v, 0);
        end

        // Reset in the middle of a fetch, with an ack arriving during and after it
        rst = 1'b0;
        cyc = 0;
        while (imem_req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        check("midrst_req", 32'(imem_req), 1);
        check("midrst_addr", imem_addr, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 8'h30;
        check("midrst_req0", 32'(imem_req), 0);
        check("midrst_pc", pc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("midrst_pc_after", pc, 8'h00);
        check("midrst_halted", 32'(halted), 0);
        check("midrst_count", instr_count, 0);
        check("midrst_refetch", 32'(imem_req), 1);
        check("midrst_refetch_addr", imem_addr, 8'h00);
        pending = 0; fixed_lat = 0; resp_en = 1;
        repeat (10) @(negedge clk);
        check("midrst_no_halt", 32'(halted), 0);

        // MVI R1,F0; MVI R2,20; SUM R1,R2; HLT with zero ack latency
        clear_mem(8'h30);
        mem[0] = 8'h14; mem[1] = 8'hF0; mem[2] = 8'h18; mem[3] = 8'h20;
        mem[4] = 8'h46; mem[5] = 8'h30;
        mon_en = 1;
        do_reset();
        wait_halt(200);
        check("sum_in1", last_in1, 8'h20);
        check("sum_in2", last_in2, 8'hF0);
        check("sum_strobes", 32'(strobe_cycles), 1);
        read_reg(2'd1, v);
        check("sum_r1", v, 8'h10);
        check("sum_flags", flags, 2'b10);
        check("sum_count", instr_count, 16'd4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_req", 32'(imem_req), 0);
        end
        check("halt_count", instr_count, 16'd4);
        do_reset();
        @(negedge clk);
        check("halt_cleared", 32'(halted), 0);

        // MVI R0,05; SBI R0,05; MOV R1,R0; SBI R0,01; HLT
        clear_mem(8'h30);
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'hD0; mem[3] = 8'h05;
        mem[4] = 8'h24; mem[5] = 8'hD0; mem[6] = 8'h01;
        fixed_lat = 1;
        do_reset();
        wait_halt(300);
        check("sbi_hist_len", 32'(flag_hist.size()), 5);
        if (flag_hist.size() == 5) begin
            check("sbi_zero_flags", flag_hist[1], 2'b01);
            check("mov_keeps_flags", flag_hist[2], 2'b01);
        end
        read_reg(2'd1, v);
        check("sbi_r1", v, 8'h00);
        read_reg(2'd0, v);
        check("sbi_r0", v, 8'hFF);
        check("sbi_flags", flags, 2'b10);

        // MVI R3,03; MVI R2,FF; SMI R2,01; CMI R3,07; HLT
        clear_mem(8'h30);
        mem[0] = 8'h1C; mem[1] = 8'h03; mem[2] = 8'h18; mem[3] = 8'hFF;
        mem[4] = 8'hC8; mem[5] = 8'h01; mem[6] = 8'hFC; mem[7] = 8'h07;
        fixed_lat = 0;
        do_reset();
        wait_halt(300);
        check("cmi_flags", flags, 2'b00);
        read_reg(2'd3, v);
        check("cmi_r3", v, 8'h03);
        read_reg(2'd2, v);
        check("smi_r2", v, 8'h00);

        // PC wrap: ORI R1,0F at FE/FF after a NOP sled, ack latency 5
        clear_mem(8'h00);
        mem[0] = 8'h14; mem[1] = 8'hA5; mem[8'hFE] = 8'h94; mem[8'hFF] = 8'h0F;
        fixed_lat = 5;
        do_reset();
        cyc = 0;
        while (instr_count != 16'd254 && cyc < 5000) begin @(negedge clk); cyc++; end
        check("wrap_count", instr_count, 16'd254);
        check("wrap_pc", pc, 8'h00);
        check("wrap_flags", flags, 2'b00);
        mon_en = 0;
        @(negedge clk);
        read_reg(2'd1, v);
        check("wrap_r1", v, 8'hAF);
        mon_en = 1;

        // Random programs, random latency, stray acks while idle
        fixed_lat = -1;
        spur_en = 1;
        for (int p = 0; p < 4; p++) begin
            clear_mem(8'h30);
            a = 0;
            for (int i = 0; i < 40; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h3) op = 4'h0;
                mem[a] = {op, 4'($urandom)};
                a++;
                if (has_imm(op)) begin mem[a] = 8'($urandom); a++; end
            end
            do_reset();
            wait_halt(3000);
            check("rand_count", instr_count, 16'd41);
        end
        spur_en = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
